// File: rtl/tilt_pkg.sv
// Shared axis-state encoding, default constants and small helpers for the tilt direction filter.
package tilt_pkg;

    typedef enum logic [1:0] {
        AXIS_REST = 2'd0,
        AXIS_POS  = 2'd1,
        AXIS_NEG  = 2'd2
    } axis_state_t;

    localparam int DEF_CENTER_X   = 32'd385;
    localparam int DEF_CENTER_Y   = 32'd80;
    localparam int DEF_DEADBAND   = 32'd8;
    localparam int DEF_DEBOUNCE   = 32'd3;
    localparam int DEF_SAMPLE_DIV = 32'd100000;

    // Floor average of a four-entry window held in 11 bits.
    function automatic logic [8:0] window_avg(input logic [8:0] a, input logic [8:0] b,
                                              input logic [8:0] c, input logic [8:0] d);
        logic [10:0] sum;
        sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
        return 9'(sum >> 2);
    endfunction

    // Level decode as {pos, neg, rest}; anything unexpected reads as rest.
    function automatic logic [2:0] axis_levels(input axis_state_t s);
        logic [2:0] lv;
        case (s)
            AXIS_POS:  lv = 3'b100;
            AXIS_NEG:  lv = 3'b010;
            AXIS_REST: lv = 3'b001;
            default:   lv = 3'b001;
        endcase
        return lv;
    endfunction

endpackage

// File: rtl/tilt_axis.sv
// One accelerometer axis: sample window, averager, hysteresis classifier and debounced state.
module tilt_axis
    import tilt_pkg::*;
#(
    parameter int CENTER   = DEF_CENTER_X,
    parameter int DEADBAND = DEF_DEADBAND,
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        strobe,
    input  logic        cal,
    input  logic [8:0]  sample,
    input  logic [8:0]  centre,
    output logic [8:0]  avg,
    output axis_state_t state,
    output axis_state_t state_next
);

    localparam logic [8:0] CENTER_W = 9'(CENTER);
    localparam logic [9:0] BAND_W   = 10'(DEADBAND);
    localparam logic [9:0] HOLD_W   = 10'(DEADBAND >> 1);
    localparam logic [7:0] DEB_W    = 8'(DEBOUNCE);

    // The fourth window entry is the live sample, so only three are stored.
    logic [8:0]  hist0_r, hist1_r, hist2_r, avg_r;
    logic        eval_r;
    axis_state_t state_r, prev_r, cand_s, state_next_s, prev_next_s;
    logic [7:0]  cnt_r, cnt_next_s, cnt_inc_s;
    logic [9:0]  avg_w_s, centre_w_s, hi_s, lo_s, hold_hi_s, hold_lo_s;
    logic        lo_ok_s, hold_lo_ok_s;

    assign avg_w_s      = {1'b0, avg_r};
    assign centre_w_s   = {1'b0, centre};
    assign hi_s         = centre_w_s + BAND_W;
    assign hold_hi_s    = centre_w_s + HOLD_W;
    assign lo_s         = centre_w_s - BAND_W;
    assign hold_lo_s    = centre_w_s - HOLD_W;
    assign lo_ok_s      = centre_w_s >= BAND_W;
    assign hold_lo_ok_s = centre_w_s >= HOLD_W;

    // Candidate direction from the current average with hysteresis around the held state.
    always_comb begin
        cand_s = AXIS_REST;
        if (avg_w_s >= hi_s) begin
            cand_s = AXIS_POS;
        end else if (lo_ok_s && (avg_w_s <= lo_s)) begin
            cand_s = AXIS_NEG;
        end else if ((state_r == AXIS_POS) && (avg_w_s >= hold_hi_s)) begin
            cand_s = AXIS_POS;
        end else if ((state_r == AXIS_NEG) && hold_lo_ok_s && (avg_w_s <= hold_lo_s)) begin
            cand_s = AXIS_NEG;
        end else begin
            cand_s = AXIS_REST;
        end
    end

    // Debounce: commit only after DEBOUNCE consecutive identical candidates; cal overrides.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        prev_next_s  = prev_r;
        cnt_inc_s    = 8'd0;
        if (cal) begin
            state_next_s = AXIS_REST;
            cnt_next_s   = 8'd0;
            prev_next_s  = AXIS_REST;
        end else if (eval_r) begin
            prev_next_s = cand_s;
            if (cand_s == state_r) begin
                cnt_next_s = 8'd0;
            end else begin
                cnt_inc_s = (cand_s == prev_r) ? (cnt_r + 8'd1) : 8'd1;
                if (cnt_inc_s >= DEB_W) begin
                    state_next_s = cand_s;
                    cnt_next_s   = 8'd0;
                end else begin
                    cnt_next_s = cnt_inc_s;
                end
            end
        end else begin
            state_next_s = state_r;
            cnt_next_s   = cnt_r;
        end
    end

    // Window, average and debounce registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            hist0_r <= CENTER_W;
            hist1_r <= CENTER_W;
            hist2_r <= CENTER_W;
            avg_r   <= CENTER_W;
            eval_r  <= 1'b0;
            state_r <= AXIS_REST;
            prev_r  <= AXIS_REST;
            cnt_r   <= 8'd0;
        end else begin
            if (strobe) begin
                hist0_r <= hist1_r;
                hist1_r <= hist2_r;
                hist2_r <= sample;
                avg_r   <= window_avg(hist0_r, hist1_r, hist2_r, sample);
            end
            eval_r  <= strobe;
            state_r <= state_next_s;
            prev_r  <= prev_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    assign avg        = avg_r;
    assign state      = state_r;
    assign state_next = state_next_s;

endmodule

// File: rtl/tilt_direction_filter.sv
// Two-axis tilt direction filter: sample pacing, calibration, direction levels and change pulse.
module tilt_direction_filter
    import tilt_pkg::*;
#(
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int CENTER_X   = DEF_CENTER_X,
    parameter int CENTER_Y   = DEF_CENTER_Y,
    parameter int DEADBAND   = DEF_DEADBAND,
    parameter int DEBOUNCE   = DEF_DEBOUNCE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] accel_x,
    input  logic [8:0] accel_y,
    input  logic       cal,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       restx,
    output logic       resty,
    output logic       change
);

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] sample_cnt_r;
    logic             strobe_s;
    logic [8:0]       centre_x_r, centre_y_r, avg_x_s, avg_y_s;
    axis_state_t      x_state_s, x_next_s, y_state_s, y_next_s;
    logic [2:0]       dir_x_r, dir_y_r;
    logic             change_r;

    assign strobe_s = (sample_cnt_r == CNT_LAST);

    // Sample pacing counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sample_cnt_r <= {CNT_W{1'b0}};
        end else if (strobe_s) begin
            sample_cnt_r <= {CNT_W{1'b0}};
        end else begin
            sample_cnt_r <= sample_cnt_r + CNT_W'(32'd1);
        end
    end

    // Centres: captured from the pre-update averages on cal.
    always_ff @(posedge clock) begin
        if (!reset) begin
            centre_x_r <= 9'(CENTER_X);
            centre_y_r <= 9'(CENTER_Y);
        end else if (cal) begin
            centre_x_r <= avg_x_s;
            centre_y_r <= avg_y_s;
        end else begin
            centre_x_r <= centre_x_r;
            centre_y_r <= centre_y_r;
        end
    end

    tilt_axis #(.CENTER(CENTER_X), .DEADBAND(DEADBAND), .DEBOUNCE(DEBOUNCE)) u_axis_x (
        .clock      (clock),
        .reset      (reset),
        .strobe     (strobe_s),
        .cal        (cal),
        .sample     (accel_x),
        .centre     (centre_x_r),
        .avg        (avg_x_s),
        .state      (x_state_s),
        .state_next (x_next_s)
    );

    tilt_axis #(.CENTER(CENTER_Y), .DEADBAND(DEADBAND), .DEBOUNCE(DEBOUNCE)) u_axis_y (
        .clock      (clock),
        .reset      (reset),
        .strobe     (strobe_s),
        .cal        (cal),
        .sample     (accel_y),
        .centre     (centre_y_r),
        .avg        (avg_y_s),
        .state      (y_state_s),
        .state_next (y_next_s)
    );

    // Levels track the next axis state so they land in the same cycle as the commit.
    always_ff @(posedge clock) begin
        if (!reset) begin
            dir_x_r  <= 3'b001;
            dir_y_r  <= 3'b001;
            change_r <= 1'b0;
        end else begin
            dir_x_r  <= axis_levels(x_next_s);
            dir_y_r  <= axis_levels(y_next_s);
            change_r <= (x_next_s != x_state_s) || (y_next_s != y_state_s);
        end
    end

    assign up     = dir_x_r[2];
    assign down   = dir_x_r[1];
    assign restx  = dir_x_r[0];
    assign right  = dir_y_r[2];
    assign left   = dir_y_r[1];
    assign resty  = dir_y_r[0];
    assign change = change_r;

endmodule

// File: tb/tb_tilt_direction_filter.sv
// Scoreboard bench: stimulus queues expected level vectors and arrival cycles; a monitor checks each change pulse.
module tb_tilt_direction_filter;

    // Level vectors ordered {up, down, left, right, restx, resty}.
    localparam logic [5:0] D_REST = 6'b000011;
    localparam logic [5:0] D_UP   = 6'b100001;
    localparam logic [5:0] D_DOWN = 6'b010001;

    logic       clock = 1'b0;
    logic       reset;
    logic       cal;
    logic       cal2;
    logic [8:0] accel_x, accel_y, accel_x2;
    logic       up, down, left, right, restx, resty, change;
    logic       up2, down2, left2, right2, restx2, resty2, change2;

    typedef struct {
        logic [5:0] dirs;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       got_e;
    logic [5:0] dirs_s;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         change2_cnt = 0;
    bit         mon_en = 1'b0;

    always #5 clock = ~clock;

    tilt_direction_filter #(.SAMPLE_DIV(4), .DEADBAND(8), .DEBOUNCE(3)) dut (
        .clock(clock), .reset(reset), .accel_x(accel_x), .accel_y(accel_y), .cal(cal),
        .up(up), .down(down), .left(left), .right(right),
        .restx(restx), .resty(resty), .change(change)
    );

    tilt_direction_filter #(.SAMPLE_DIV(4), .CENTER_X(510), .DEADBAND(8), .DEBOUNCE(3)) dut_hi (
        .clock(clock), .reset(reset), .accel_x(accel_x2), .accel_y(accel_y), .cal(cal2),
        .up(up2), .down(down2), .left(left2), .right(right2),
        .restx(restx2), .resty(resty2), .change(change2)
    );

    // Cycle index since reset release; cycle k holds sample count k mod 4.
    always @(posedge clock) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Monitor: level sanity every cycle, and scoreboard pop on every change pulse.
    always @(negedge clock) begin
        if (mon_en) begin
            dirs_s = {up, down, left, right, restx, resty};
            checks++;
            if (!($onehot({up, down, restx}) && $onehot({left, right, resty}))) begin
                errors++;
                $display("FAIL onehot: got %b at cycle %0d", dirs_s, cyc);
            end
            checks++;
            if (up2 !== 1'b0) begin
                errors++;
                $display("FAIL clamp_up: up=%b want 0 at cycle %0d", up2, cyc);
            end
            if (change2 === 1'b1) change2_cnt++;
            if (change === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_change: levels %b at cycle %0d, none expected", dirs_s, cyc);
                end else begin
                    got_e = exp_q.pop_front();
                    if ((dirs_s !== got_e.dirs) || (cyc != got_e.cyc)) begin
                        errors++;
                        $display("FAIL change: got %b at cycle %0d, want %b at cycle %0d",
                                 dirs_s, cyc, got_e.dirs, got_e.cyc);
                    end
                end
            end
        end
    end

    // One sample period; the strobe falls in its last cycle, so a commit shows 5 cycles after entry.
    task automatic step(input logic [8:0] xv, input logic [8:0] yv, input bit push, input logic [5:0] dirs);
        exp_t e;
        accel_x = xv;
        accel_y = yv;
        if (push) begin
            e.dirs = dirs;
            e.cyc  = cyc + 5;
            exp_q.push_back(e);
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic do_cal(input logic [5:0] dirs);
        exp_t e;
        cal    = 1'b1;
        e.dirs = dirs;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        @(negedge clock);
        cal = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        reset    = 1'b0;
        cal      = 1'b0;
        cal2     = 1'b0;
        accel_x  = 9'd385;
        accel_y  = 9'd80;
        accel_x2 = 9'd511;
        repeat (3) @(negedge clock);
        mon_en = 1'b1;
        checks++;
        if ({up, down, left, right, restx, resty, change} !== {D_REST, 1'b0}) begin
            errors++;
            $display("FAIL reset_levels: got %b want %b", {up, down, left, right, restx, resty, change}, {D_REST, 1'b0});
        end
        reset = 1'b1;

        // At rest for 40 cycles: no change pulse may appear.
        for (int i = 0; i < 10; i++) step(9'd385, 9'd80, 1'b0, D_REST);

        // x=400: averages 388, 392, 396, 400, 400 -> third qualifying sample commits up.
        for (int i = 0; i < 6; i++) step(9'd400, 9'd80, (i == 4), D_UP);

        // x=388: averages 397, 394, 391 hold up; 388 (<389) three times returns to rest.
        for (int i = 0; i < 7; i++) step(9'd388, 9'd80, (i == 5), D_REST);

        // A 2-periodic y averages flat over a 4-deep window, so a 3-periodic 40/100/100
        // pattern makes the left candidate appear once in three and restart the count.
        for (int i = 0; i < 9; i++) step(9'd385, ((i % 3) == 0) ? 9'd40 : 9'd100, 1'b0, D_REST);
        for (int i = 0; i < 4; i++) step(9'd385, 9'd80, 1'b0, D_REST);

        // x=300: averages 363, 342, 321 commit down; then cal recentres at 300.
        for (int i = 0; i < 4; i++) step(9'd300, 9'd80, (i == 2), D_DOWN);
        do_cal(D_REST);
        for (int i = 0; i < 4; i++) step(9'd300, 9'd80, 1'b0, D_REST);
        checks++;
        if ({up, down, left, right, restx, resty} !== D_REST) begin
            errors++;
            $display("FAIL after_cal: got %b want %b", {up, down, left, right, restx, resty}, D_REST);
        end

        // Centre 510: x=0 builds two NEG samples, then reset lands mid-debounce.
        accel_x2 = 9'd0;
        for (int i = 0; i < 2; i++) step(9'd300, 9'd80, 1'b0, D_REST);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        accel_x2 = 9'd511;
        reset    = 1'b1;
        for (int i = 0; i < 4; i++) step(9'd385, 9'd80, 1'b0, D_REST);

        checks++;
        if (change2_cnt != 0) begin
            errors++;
            $display("FAIL hi_change: pulses=%0d want 0", change2_cnt);
        end
        checks++;
        if ({up2, down2, left2, right2, restx2, resty2} !== D_REST) begin
            errors++;
            $display("FAIL hi_levels: got %b want %b", {up2, down2, left2, right2, restx2, resty2}, D_REST);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending: %0d expected changes never seen, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
